// File: rtl/univ_shift_reg_burst.sv
// Parametrised universal shift register with eight modes and a burst engine.
// A burst applies one latched shift/rotate mode to the register `count` times.
module univ_shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] INP,
   input  logic             leftInp,
   input  logic             rightInp,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] OUT,
   output logic             msbOut,
   output logic             lsbOut,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   localparam logic [2:0] SEL_HOLD  = 3'b000;
   localparam logic [2:0] SEL_SR    = 3'b001;
   localparam logic [2:0] SEL_SL    = 3'b010;
   localparam logic [2:0] SEL_LOAD  = 3'b011;
   localparam logic [2:0] SEL_ROR   = 3'b100;
   localparam logic [2:0] SEL_ROL   = 3'b101;
   localparam logic [2:0] SEL_ASR   = 3'b110;
   localparam logic [2:0] SEL_CLEAR = 3'b111;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [2:0]       mode_q, mode_d;
   logic             done_q, done_d;
   logic             sel_is_shift;

   function automatic logic [WIDTH-1:0] apply_mode(
      input logic [2:0]       mode,
      input logic [WIDTH-1:0] val,
      input logic [WIDTH-1:0] load_val,
      input logic             li,
      input logic             ri
   );
      logic [WIDTH-1:0] res;
      res = val;
      case (mode)
         SEL_HOLD:  res = val;
         SEL_SR:    res = {li, val[WIDTH-1:1]};
         SEL_SL:    res = {val[WIDTH-2:0], ri};
         SEL_LOAD:  res = load_val;
         SEL_ROR:   res = {val[0], val[WIDTH-1:1]};
         SEL_ROL:   res = {val[WIDTH-2:0], val[WIDTH-1]};
         SEL_ASR:   res = {val[WIDTH-1], val[WIDTH-1:1]};
         SEL_CLEAR: res = '0;
         default:   res = val;
      endcase
      return res;
   endfunction

   // Only shift/rotate codes can launch a burst; hold, load and clear ignore start.
   assign sel_is_shift = (select != SEL_HOLD) && (select != SEL_LOAD) && (select != SEL_CLEAR);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (EN) begin
         case (state_q)
            IDLE: begin
               if (start && sel_is_shift) begin
                  mode_d = select;
                  rem_d  = count;
                  if (count != '0) begin
                     state_d = BURST;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  out_d = apply_mode(select, out_q, INP, leftInp, rightInp);
               end
            end
            BURST: begin
               out_d = apply_mode(mode_q, out_q, INP, leftInp, rightInp);
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         out_q   <= '0;
         rem_q   <= '0;
         mode_q  <= SEL_HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign OUT    = out_q;
   assign msbOut = out_q[WIDTH-1];
   assign lsbOut = out_q[0];
   assign busy   = (state_q == BURST);
   assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Scoreboard bench for univ_shift_reg_burst: stimulus queues expected state per edge,
// a negedge monitor pops and compares.
module tb_univ_shift_reg_burst;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic [2:0] select;
   logic [7:0] INP;
   logic       leftInp;
   logic       rightInp;
   logic       start;
   logic [3:0] count;
   logic [7:0] OUT;
   logic       msbOut;
   logic       lsbOut;
   logic       busy;
   logic       done;

   typedef struct {
      string      name;
      logic [7:0] out;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   univ_shift_reg_burst #(
      .WIDTH(8),
      .CNT_W(4)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .select   (select),
      .INP      (INP),
      .leftInp  (leftInp),
      .rightInp (rightInp),
      .start    (start),
      .count    (count),
      .OUT      (OUT),
      .msbOut   (msbOut),
      .lsbOut   (lsbOut),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (OUT !== e.out || busy !== e.busy || done !== e.done ||
             msbOut !== e.out[7] || lsbOut !== e.out[0]) begin
            failures++;
            $display("FAIL %s: got OUT=%h busy=%b done=%b msb=%b lsb=%b, want OUT=%h busy=%b done=%b msb=%b lsb=%b",
                     e.name, OUT, busy, done, msbOut, lsbOut,
                     e.out, e.busy, e.done, e.out[7], e.out[0]);
         end
      end
   end

   task automatic push_exp(input string name, input logic [7:0] eo, input logic eb,
                           input logic ed);
      exp_t e;
      e.name = name;
      e.out  = eo;
      e.busy = eb;
      e.done = ed;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input string name, input logic en, input logic [2:0] sel,
                      input logic [7:0] inp, input logic li, input logic ri,
                      input logic st, input logic [3:0] cnt,
                      input logic [7:0] eo, input logic eb, input logic ed);
      RST_N    = 1'b1;
      EN       = en;
      select   = sel;
      INP      = inp;
      leftInp  = li;
      rightInp = ri;
      start    = st;
      count    = cnt;
      @(posedge CLK);
      #1;
      push_exp(name, eo, eb, ed);
   endtask

   // Reset asserted just after an edge, so the check sees the asynchronous effect.
   task automatic cyc_rst(input string name, input logic [2:0] sel, input logic st,
                          input logic [3:0] cnt);
      EN     = 1'b1;
      select = sel;
      start  = st;
      count  = cnt;
      @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      push_exp(name, 8'h00, 1'b0, 1'b0);
   endtask

   logic [7:0] asr_tab [9];

   initial begin
      asr_tab = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
      RST_N = 1'b0; EN = 1'b0; select = 3'd0; INP = 8'h00;
      leftInp = 1'b0; rightInp = 1'b0; start = 1'b0; count = 4'd0;

      cyc_rst("reset_init", 3'd0, 1'b0, 4'd0);

      // load and hold
      cyc("load_96", 1, 3'd3, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
      for (int i = 0; i < 3; i++) cyc("hold_96", 1, 3'd0, 8'h55, 1, 1, 0, 4'd0, 8'h96, 0, 0);
      cyc("en0_hold", 0, 3'd7, 8'h00, 0, 0, 1, 4'd2, 8'h96, 0, 0);

      // shifts
      cyc("sr_li1", 1, 3'd1, 8'h00, 1, 0, 0, 4'd0, 8'hCB, 0, 0);
      cyc("load_96", 1, 3'd3, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
      cyc("sl_ri0", 1, 3'd2, 8'h00, 1, 0, 0, 4'd0, 8'h2C, 0, 0);
      cyc("clear", 1, 3'd7, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

      // rotates
      cyc("load_96", 1, 3'd3, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
      cyc("ror", 1, 3'd4, 8'h00, 0, 1, 0, 4'd0, 8'h4B, 0, 0);
      cyc("load_96", 1, 3'd3, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
      cyc("rol", 1, 3'd5, 8'h00, 1, 0, 0, 4'd0, 8'h2D, 0, 0);
      cyc("load_96", 1, 3'd3, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
      cyc("asr", 1, 3'd6, 8'h00, 0, 0, 0, 4'd0, 8'hCB, 0, 0);

      // ROL burst of 3 from 81; select/INP/start changes during burst must be ignored
      cyc("load_81", 1, 3'd3, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
      cyc("rol_start", 1, 3'd5, 8'h00, 0, 0, 1, 4'd3, 8'h81, 1, 0);
      cyc("rol_b1", 1, 3'd3, 8'hFF, 0, 0, 1, 4'd7, 8'h03, 1, 0);
      cyc("rol_b2", 1, 3'd7, 8'hFF, 0, 0, 1, 4'd7, 8'h06, 1, 0);
      cyc("rol_done", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 1);
      cyc("rol_after", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 0);

      // SR burst of 4 with live leftInp and a 2-cycle EN pause
      cyc("load_0f", 1, 3'd3, 8'h0F, 0, 0, 0, 4'd0, 8'h0F, 0, 0);
      cyc("sr_start", 1, 3'd1, 8'h00, 1, 0, 1, 4'd4, 8'h0F, 1, 0);
      cyc("sr_b1", 1, 3'd0, 8'h00, 1, 0, 0, 4'd0, 8'h87, 1, 0);
      cyc("sr_pause1", 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h87, 1, 0);
      cyc("sr_pause2", 0, 3'd0, 8'h00, 1, 0, 0, 4'd0, 8'h87, 1, 0);
      cyc("sr_b2", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h43, 1, 0);
      cyc("sr_b3", 1, 3'd0, 8'h00, 1, 0, 0, 4'd0, 8'hA1, 1, 0);
      cyc("sr_done", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h50, 0, 1);

      // zero-count start: done only, OUT unchanged
      cyc("cnt0_start", 1, 3'd4, 8'h00, 0, 0, 1, 4'd0, 8'h50, 0, 1);
      cyc("cnt0_after", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h50, 0, 0);

      // ASR burst longer than the width saturates to the sign fill
      cyc("load_80", 1, 3'd3, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0);
      cyc("asr_start", 1, 3'd6, 8'h00, 0, 0, 1, 4'd9, 8'h80, 1, 0);
      for (int i = 0; i < 9; i++)
         cyc("asr_sat", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, asr_tab[i], (i < 8), (i == 8));

      // reset mid-burst, then start with load code acts as plain load
      cyc("load_81b", 1, 3'd3, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
      cyc("rol5_start", 1, 3'd5, 8'h00, 0, 0, 1, 4'd5, 8'h81, 1, 0);
      cyc("rol5_b1", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0);
      cyc_rst("reset_mid", 3'd0, 1'b0, 4'd0);
      cyc("start_load", 1, 3'd3, 8'h5A, 0, 0, 1, 4'd3, 8'h5A, 0, 0);
      cyc("start_load_hold", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0);

      @(negedge CLK);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
